// File: rtl/lcd_bus_reader.sv
// HD44780 bus read engine: timed RW=1 cycles returning BF/address or a data byte, with optional busy polling.
// Latency: o_valid pulses A+H+L+1 cycles after accept per read (53+1 at defaults); poll repeats the A+H+L read.
// Backpressure: o_ready=1 only in IDLE/DONE; requests while busy are dropped, nothing is queued.
module lcd_bus_reader #(
  parameter int SIZE_DATA = 8,
  parameter int FREQ      = 50_000_000,
  parameter int T_AS_NS   = 60,
  parameter int T_EH_NS   = 500,
  parameter int T_EL_NS   = 500,
  parameter int MAX_POLL  = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [1:0]           i_func,
  input  logic [SIZE_DATA-1:0] i_LCD_DATA,
  output logic                 o_LCD_E,
  output logic                 o_LCD_RW,
  output logic                 o_LCD_RS,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_busy_flag,
  output logic [6:0]           o_addr,
  output logic                 o_valid,
  output logic                 o_timeout,
  output logic                 o_ready
);

  // ns -> clock cycles, rounded up and never below one cycle
  function automatic int ns_to_cycles(input longint ns);
    longint c;
    c = (ns * longint'(FREQ) + longint'(999_999_999)) / longint'(1_000_000_000);
    if (c < longint'(1)) c = longint'(1);
    return int'(c);
  endfunction

  localparam int A    = ns_to_cycles(longint'(T_AS_NS));
  localparam int H    = ns_to_cycles(longint'(T_EH_NS));
  localparam int L    = ns_to_cycles(longint'(T_EL_NS));
  localparam int CMAX = (A > H) ? ((A > L) ? A : L) : ((H > L) ? H : L);
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int PW   = $clog2(MAX_POLL) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, ELOW, DONE} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [PW-1:0]          poll, poll_n;
  logic                   poll_mode, poll_mode_n;
  logic                   e_n, rw_n, rs_n, valid_n, timeout_n, ready_n;
  logic [SIZE_DATA-1:0]   data_n;
  logic                   finish;

  // BF and address are fixed bit slices of the last sampled byte
  assign o_busy_flag = o_data[7];
  assign o_addr      = o_data[6:0];

  // Register every output together with the FSM state; reset forces the idle bus immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      poll      <= '0;
      poll_mode <= 1'b0;
      o_LCD_E   <= 1'b0;
      o_LCD_RW  <= 1'b0;
      o_LCD_RS  <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      poll      <= poll_n;
      poll_mode <= poll_mode_n;
      o_LCD_E   <= e_n;
      o_LCD_RW  <= rw_n;
      o_LCD_RS  <= rs_n;
      o_data    <= data_n;
      o_valid   <= valid_n;
      o_timeout <= timeout_n;
      o_ready   <= ready_n;
    end
  end

  // Next state and next registered outputs; RS/RW only move outside the E-high window
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    poll_n      = poll;
    poll_mode_n = poll_mode;
    e_n         = o_LCD_E;
    rw_n        = o_LCD_RW;
    rs_n        = o_LCD_RS;
    data_n      = o_data;
    valid_n     = 1'b0;
    timeout_n   = o_timeout;
    ready_n     = o_ready;
    finish      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (i_req) begin
          state_n     = SETUP;
          cnt_n       = '0;
          poll_n      = '0;
          poll_mode_n = (i_func == 2'd2);
          rs_n        = (i_func == 2'd1);
          rw_n        = 1'b1;
          e_n         = 1'b0;
          timeout_n   = 1'b0;
          ready_n     = 1'b0;
        end else begin
          state_n = IDLE;
          rw_n    = 1'b0;
          rs_n    = 1'b0;
          e_n     = 1'b0;
          ready_n = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == CW'(A - 1)) begin
          state_n = EHIGH;
          cnt_n   = '0;
          e_n     = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EHIGH: begin
        if (cnt == CW'(H - 1)) begin
          data_n  = i_LCD_DATA;
          state_n = ELOW;
          cnt_n   = '0;
          e_n     = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ELOW: begin
        if (cnt == CW'(L - 1)) begin
          cnt_n = '0;
          if (poll_mode && o_data[7]) begin
            if (poll == PW'(MAX_POLL - 1)) begin
              timeout_n = 1'b1;
              finish    = 1'b1;
            end else begin
              poll_n  = poll + 1'b1;
              state_n = SETUP;
            end
          end else begin
            finish = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase

    if (finish) begin
      state_n = DONE;
      valid_n = 1'b1;
      rw_n    = 1'b0;
      rs_n    = 1'b0;
      ready_n = 1'b1;
    end
  end

endmodule
